sump_cmd_decoder: RTL

Receive-side counterpart of the SUMP metadata/ID transmitter. It consumes bytes from the UART receiver and parses SUMP short (1-byte) and long (5-byte) commands. It issues action pulses (reset, arm), drives the metadata/ID request handshake toward the metadata sender, and holds the capture configuration registers read by the sampler/trigger logic.

---
 rtl/sump_pkg.sv | 30 +++
 rtl/sump_cmd_decoder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sump_pkg.sv
// SUMP protocol constants and decoder state encoding.
// Contents:
//   - SUMP_* opcode values for short (bit 7 = 0) and long (bit 7 = 1) commands
//   - decoder_state_t : command decoder FSM states
//   - is_cfg_op()     : 1 for long opcodes that map to a configuration register
package sump_pkg;

  localparam logic [7:0] SUMP_RESET = 8'h00;
  localparam logic [7:0] SUMP_RUN   = 8'h01;
  localparam logic [7:0] SUMP_ID    = 8'h02;
  localparam logic [7:0] SUMP_META  = 8'h04;
  localparam logic [7:0] SUMP_XON   = 8'h11;
  localparam logic [7:0] SUMP_XOFF  = 8'h13;
  localparam logic [7:0] SUMP_DIV   = 8'h80;
  localparam logic [7:0] SUMP_CNT   = 8'h81;
  localparam logic [7:0] SUMP_FLAGS = 8'h82;
  localparam logic [7:0] SUMP_TMASK = 8'hC0;
  localparam logic [7:0] SUMP_TVAL  = 8'hC1;
  localparam logic [7:0] SUMP_TCFG  = 8'hC2;

  typedef enum logic [1:0] {IDLE, LONG, META_REQ, META_WAIT} decoder_state_t;

  function automatic logic is_cfg_op(input logic [7:0] op);
    case (op)
      SUMP_DIV, SUMP_CNT, SUMP_FLAGS, SUMP_TMASK, SUMP_TVAL, SUMP_TCFG: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sump_cmd_decoder.sv
// SUMP command decoder: parses short (1-byte) and long (opcode + 4 data
// bytes, little-endian) commands from the UART receiver.
// Ports:
//   clock, reset_n          : clock, async active-low reset
//   rx_valid, rx_byte       : received byte strobe / data
//   meta_busy               : metadata sender busy
//   begin_meta_transmit     : metadata/ID request, held until meta_busy seen
//   send_id                 : 1 = ID, 0 = metadata (changes only when a request starts)
//   cmd_reset, cmd_arm      : one-cycle action pulses
//   cfg_update              : one-cycle pulse on any config register write
//   divider .. flags        : capture configuration registers
//   cmd_dropped             : one-cycle pulse when a byte/partial command is discarded
module sump_cmd_decoder
  import sump_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  input  logic        meta_busy,
  output logic        begin_meta_transmit,
  output logic        send_id,
  output logic        cmd_reset,
  output logic        cmd_arm,
  output logic        cfg_update,
  output logic [23:0] divider,
  output logic [15:0] read_count,
  output logic [15:0] delay_count,
  output logic [31:0] trig_mask,
  output logic [31:0] trig_value,
  output logic [31:0] trig_config,
  output logic [31:0] flags,
  output logic        cmd_dropped
);

  decoder_state_t state, state_n;
  logic [7:0]       opcode, opcode_n;
  // Only the three earlier data bytes need storing; the 4th byte is taken
  // straight from rx_byte when the word is assembled.
  logic [23:0]      shreg, shreg_n;
  logic [1:0]       idx, idx_n;
  logic [CNT_W-1:0] tmr, tmr_n;
  logic [31:0]      data_n;
  logic             send_id_n, bmt_n, reset_p, arm_p, drop_p, cfg_wr;

  always_comb begin
    state_n   = state;
    opcode_n  = opcode;
    shreg_n   = shreg;
    idx_n     = idx;
    tmr_n     = tmr;
    send_id_n = send_id;
    bmt_n     = begin_meta_transmit;
    reset_p   = 1'b0;
    arm_p     = 1'b0;
    drop_p    = 1'b0;
    cfg_wr    = 1'b0;
    data_n    = {rx_byte, shreg};

    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_byte[7]) begin
            opcode_n = rx_byte;
            shreg_n  = '0;
            idx_n    = '0;
            tmr_n    = '0;
            state_n  = LONG;
          end else begin
            case (rx_byte)
              SUMP_RESET: reset_p = 1'b1;
              SUMP_RUN:   arm_p   = 1'b1;
              SUMP_ID:    begin send_id_n = 1'b1; bmt_n = 1'b1; state_n = META_REQ; end
              SUMP_META:  begin send_id_n = 1'b0; bmt_n = 1'b1; state_n = META_REQ; end
              default: ;  // XON/XOFF and unknown short opcodes are ignored
            endcase
          end
        end
      end

      LONG: begin
        if (rx_valid) begin
          shreg_n = data_n[31:8];
          idx_n   = idx + 2'd1;
          tmr_n   = '0;
          if (idx == 2'd3) begin
            cfg_wr  = is_cfg_op(opcode);
            state_n = IDLE;
          end
        end else begin
          tmr_n = tmr + 1'b1;
          if (tmr_n == CNT_W'(TIMEOUT_CYCLES)) begin
            drop_p  = 1'b1;
            tmr_n   = '0;
            state_n = IDLE;
          end
        end
      end

      META_REQ, META_WAIT: begin
        if (state == META_REQ) begin
          if (meta_busy) begin
            bmt_n   = 1'b0;
            state_n = META_WAIT;
          end
        end else if (!meta_busy) begin
          state_n = IDLE;
        end
        // Reset is still honoured while a metadata transfer is pending;
        // everything else is discarded without disturbing the handshake.
        if (rx_valid) begin
          if (rx_byte == SUMP_RESET) reset_p = 1'b1;
          else                       drop_p  = 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      opcode              <= '0;
      shreg               <= '0;
      idx                 <= '0;
      tmr                 <= '0;
      send_id             <= 1'b0;
      begin_meta_transmit <= 1'b0;
      cmd_reset           <= 1'b0;
      cmd_arm             <= 1'b0;
      cmd_dropped         <= 1'b0;
      cfg_update          <= 1'b0;
    end else begin
      state               <= state_n;
      opcode              <= opcode_n;
      shreg               <= shreg_n;
      idx                 <= idx_n;
      tmr                 <= tmr_n;
      send_id             <= send_id_n;
      begin_meta_transmit <= bmt_n;
      cmd_reset           <= reset_p;
      cmd_arm             <= arm_p;
      cmd_dropped         <= drop_p;
      cfg_update          <= cfg_wr;
    end
  end

  // Config registers: cleared only by reset_n, never by cmd_reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      divider     <= '0;
      read_count  <= '0;
      delay_count <= '0;
      trig_mask   <= '0;
      trig_value  <= '0;
      trig_config <= '0;
      flags       <= '0;
    end else if (cfg_wr) begin
      case (opcode)
        SUMP_DIV:   divider <= data_n[23:0];
        SUMP_CNT:   begin read_count <= data_n[15:0]; delay_count <= data_n[31:16]; end
        SUMP_FLAGS: flags       <= data_n;
        SUMP_TMASK: trig_mask   <= data_n;
        SUMP_TVAL:  trig_value  <= data_n;
        SUMP_TCFG:  trig_config <= data_n;
        default: ;
      endcase
    end
  end

endmodule
